// File: rtl/prim_present_dec_iter_if.sv
// ---------------------------------------------------------------------------
// prim_present_dec_iter_if
//
// Request/response bundle of the iterative PRESENT decryption engine.
//
// Signals:
//   valid_i   request valid (ciphertext + key presented)
//   ready_o   engine can accept a request
//   data_i    ciphertext, DataWidth bits
//   key_i     encryption key K, KeyWidth bits
//   key_clr_i invalidate the engine's derived-key cache
//   valid_o   plaintext valid
//   ready_i   consumer accepts the plaintext
//   data_o    plaintext, DataWidth bits
//   busy_o    engine is expanding the key or decrypting
//
// Modports:
//   master  the requester/consumer side
//   slave   the engine side
// ---------------------------------------------------------------------------
interface prim_present_dec_iter_if #(
  parameter int DataWidth = 64,
  parameter int KeyWidth  = 128
);

  logic                 valid_i;
  logic                 ready_o;
  logic [DataWidth-1:0] data_i;
  logic [KeyWidth-1:0]  key_i;
  logic                 key_clr_i;
  logic                 valid_o;
  logic                 ready_i;
  logic [DataWidth-1:0] data_o;
  logic                 busy_o;

  modport master (
    output valid_i, data_i, key_i, key_clr_i, ready_i,
    input  ready_o, valid_o, data_o, busy_o
  );

  modport slave (
    input  valid_i, data_i, key_i, key_clr_i, ready_i,
    output ready_o, valid_o, data_o, busy_o
  );

endinterface

// File: rtl/prim_present_dec_iter.sv
// ---------------------------------------------------------------------------
// prim_present_dec_iter
//
// Iterative PRESENT decryption engine. One inverse round and one key-schedule
// step are instantiated and reused every cycle. Before decrypting, the
// decryption key (the round key after NumRounds forward schedule steps) is
// derived by running the forward key schedule; the last derived key is kept
// in a single-entry cache so back-to-back blocks under the same key go
// straight to decryption.
//
// Parameters:
//   DataWidth  block width, 32 or 64
//   KeyWidth   key width, 64 (with DataWidth 32), 80 or 128
//   NumRounds  rounds, 1..31; must match the encrypting side
//
// Ports:
//   clk_i   clock, rising edge
//   rst_i   synchronous active-high reset
//   bus     request/response bundle (slave modport), see the interface file
//
// Latency from the accepting edge T: valid_o in cycle T+2*NumRounds+1 on a
// cache miss, T+NumRounds+1 on a cache hit.
// ---------------------------------------------------------------------------
module prim_present_dec_iter #(
  parameter int DataWidth = 64,
  parameter int KeyWidth  = 128,
  parameter int NumRounds = 31
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  prim_present_dec_iter_if.slave bus
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_KEYEXP = 2'd1;
  localparam logic [1:0] ST_DEC    = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [4:0] LAST_IDX = 5'(NumRounds);
  localparam int         NIBBLES  = DataWidth / 4;
  // Round counter is injected at bits 66:62 for 128-bit keys, 19:15 otherwise.
  localparam int         CNT_LSB  = (KeyWidth == 128) ? 62 : 15;

  // -------------------------------------------------------------------------
  // PRESENT primitives
  // -------------------------------------------------------------------------
  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0:    y = 4'hC;
      4'h1:    y = 4'h5;
      4'h2:    y = 4'h6;
      4'h3:    y = 4'hB;
      4'h4:    y = 4'h9;
      4'h5:    y = 4'h0;
      4'h6:    y = 4'hA;
      4'h7:    y = 4'hD;
      4'h8:    y = 4'h3;
      4'h9:    y = 4'hE;
      4'hA:    y = 4'hF;
      4'hB:    y = 4'h8;
      4'hC:    y = 4'h4;
      4'hD:    y = 4'h7;
      4'hE:    y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox4_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0:    y = 4'h5;
      4'h1:    y = 4'hE;
      4'h2:    y = 4'hF;
      4'h3:    y = 4'h8;
      4'h4:    y = 4'hC;
      4'h5:    y = 4'h1;
      4'h6:    y = 4'h2;
      4'h7:    y = 4'hD;
      4'h8:    y = 4'hB;
      4'h9:    y = 4'h4;
      4'hA:    y = 4'h6;
      4'hB:    y = 4'h3;
      4'hC:    y = 4'h0;
      4'hD:    y = 4'h7;
      4'hE:    y = 4'h9;
      default: y = 4'hA;
    endcase
    return y;
  endfunction

  // Inverse bit permutation. The forward layer moves bit i to
  // P(i) = i*(DataWidth/4) mod (DataWidth-1), with the top bit fixed, so the
  // inverse simply gathers bit i from P(i).
  function automatic logic [DataWidth-1:0] perm_inv(input logic [DataWidth-1:0] s);
    logic [DataWidth-1:0] o;
    // NOTE: o gets a full default before the loop, so no bit is ever left
    // unassigned on any path and no storage is implied.
    o = '0;
    for (int i = 0; i < DataWidth - 1; i++) begin
      o[i] = s[(i * NIBBLES) % (DataWidth - 1)];
    end
    o[DataWidth-1] = s[DataWidth-1];
    return o;
  endfunction

  function automatic logic [DataWidth-1:0] sbox_inv_layer(input logic [DataWidth-1:0] s);
    logic [DataWidth-1:0] o;
    o = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      o[4*n +: 4] = sbox4_inv(s[4*n +: 4]);
    end
    return o;
  endfunction

  // Forward key schedule step: rotate left by 61, S-box on the top nibble
  // (top two nibbles for 128-bit keys), XOR the round counter.
  function automatic logic [KeyWidth-1:0] update_key(input logic [KeyWidth-1:0] k,
                                                     input logic [4:0]          idx);
    logic [KeyWidth-1:0] r;
    r = {k[KeyWidth-62:0], k[KeyWidth-1:KeyWidth-61]};
    r[KeyWidth-1 -: 4] = sbox4(r[KeyWidth-1 -: 4]);
    if (KeyWidth == 128) begin
      r[KeyWidth-5 -: 4] = sbox4(r[KeyWidth-5 -: 4]);
    end
    r[CNT_LSB +: 5] = r[CNT_LSB +: 5] ^ idx;
    return r;
  endfunction

  // Exact inverse of update_key: undo the counter XOR, the S-box(es), then
  // rotate right by 61.
  function automatic logic [KeyWidth-1:0] inv_update_key(input logic [KeyWidth-1:0] k,
                                                         input logic [4:0]          idx);
    logic [KeyWidth-1:0] r;
    r = k;
    r[CNT_LSB +: 5] = r[CNT_LSB +: 5] ^ idx;
    r[KeyWidth-1 -: 4] = sbox4_inv(r[KeyWidth-1 -: 4]);
    if (KeyWidth == 128) begin
      r[KeyWidth-5 -: 4] = sbox4_inv(r[KeyWidth-5 -: 4]);
    end
    return {r[60:0], r[KeyWidth-1:61]};
  endfunction

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [1:0]           fsm_q;
  logic [DataWidth-1:0] state_q;
  logic [KeyWidth-1:0]  key_q;
  logic [DataWidth-1:0] data_q;
  logic [4:0]           idx_q;
  logic                 cache_vld_q;
  logic [KeyWidth-1:0]  cache_key_q;
  logic [KeyWidth-1:0]  cache_dkey_q;
  // A key_clr_i seen during expansion must keep the result out of the cache.
  logic                 clr_seen_q;

  // -------------------------------------------------------------------------
  // Shared round datapath
  // -------------------------------------------------------------------------
  logic                 accept;
  logic                 cache_hit;
  logic [KeyWidth-1:0]  fwd_key;
  logic [KeyWidth-1:0]  inv_key;
  logic [DataWidth-1:0] dec_state;

  assign accept    = bus.valid_i && (fsm_q == ST_IDLE);
  // A clear on the accepting edge forces the miss path.
  assign cache_hit = cache_vld_q && !bus.key_clr_i && (bus.key_i == cache_key_q);

  assign fwd_key   = update_key(key_q, idx_q);
  assign inv_key   = inv_update_key(key_q, idx_q);
  assign dec_state = sbox_inv_layer(perm_inv(state_q ^ key_q[KeyWidth-1 -: DataWidth]));

  // -------------------------------------------------------------------------
  // Control and state update
  // -------------------------------------------------------------------------
  // NOTE: every register here uses non-blocking assignments so that all of
  // them sample the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q        <= ST_IDLE;
      state_q      <= '0;
      key_q        <= '0;
      data_q       <= '0;
      idx_q        <= '0;
      clr_seen_q   <= 1'b0;
      // NOTE: the single cache entry is reset like any other register, so
      // no stale key/decryption-key pair can survive a reset.
      cache_vld_q  <= 1'b0;
      cache_key_q  <= '0;
      cache_dkey_q <= '0;
    end else begin
      // Clear wins in every state; later assignments below only ever write
      // cache_vld_q in ways that already account for key_clr_i.
      if (bus.key_clr_i) begin
        cache_vld_q <= 1'b0;
      end

      case (fsm_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= bus.data_i;
            if (cache_hit) begin
              key_q <= cache_dkey_q;
              idx_q <= LAST_IDX;
              fsm_q <= ST_DEC;
            end else begin
              // The entry is replaced: tag it with K now, validate it only
              // once the expansion has completed without a clear.
              key_q       <= bus.key_i;
              idx_q       <= 5'd1;
              cache_key_q <= bus.key_i;
              cache_vld_q <= 1'b0;
              clr_seen_q  <= 1'b0;
              fsm_q       <= ST_KEYEXP;
            end
          end
        end

        ST_KEYEXP: begin
          key_q <= fwd_key;
          if (idx_q == LAST_IDX) begin
            cache_dkey_q <= fwd_key;
            cache_vld_q  <= !(clr_seen_q || bus.key_clr_i);
            idx_q        <= LAST_IDX;
            fsm_q        <= ST_DEC;
          end else begin
            idx_q <= idx_q + 5'd1;
            if (bus.key_clr_i) begin
              clr_seen_q <= 1'b1;
            end
          end
        end

        ST_DEC: begin
          state_q <= dec_state;
          key_q   <= inv_key;
          idx_q   <= idx_q - 5'd1;
          if (idx_q == 5'd1) begin
            // Final whitening with the first round key K1.
            data_q <= dec_state ^ inv_key[KeyWidth-1 -: DataWidth];
            fsm_q  <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (bus.ready_i) begin
            fsm_q <= ST_IDLE;
          end
        end

        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.ready_o = (fsm_q == ST_IDLE);
  assign bus.valid_o = (fsm_q == ST_DONE);
  assign bus.busy_o  = (fsm_q == ST_KEYEXP) || (fsm_q == ST_DEC);
  assign bus.data_o  = data_q;

endmodule
